// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// funct codes, ALU function selects and the controller-to-decoder aluop.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the controller's aluop (and funct for R-type) onto the ALU's 3-bit F select.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing datapath enables plus ALU decode.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch, br_cond;
  logic       ir_write_s, mem_write_s, reg_write_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    aluop       = ALUOP_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_s = 1'b1;
        pcwrite    = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BEQEX;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      S_JEX: begin
        pc_src  = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef MIPS_MC_BNE_EN
  // Flag marks the instruction in flight as bne so BEQEX inverts the zero test.
  logic bne_q, bne_d;

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_FETCH)       bne_d = 1'b0;
    else if (state_q == S_DECODE) bne_d = (opcode == OP_BNE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bne_q <= 1'b0;
    else          bne_q <= bne_d;
  end

  assign br_cond = bne_q ? ~zero : zero;
`else
  assign br_cond = zero;
`endif

  // Write enables are held off combinationally for the whole reset window.
  assign pc_en     = reset_n & (pcwrite | (branch & br_cond));
  assign ir_write  = reset_n & ir_write_s;
  assign mem_write = reset_n & mem_write_s;
  assign reg_write = reset_n & reg_write_s;
  assign state_o   = state_q;

  mips_alu_decoder u_alu_dec (
    .aluop_i       (aluop),
    .funct_i       (funct),
    .alu_control_o (alu_control)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed instructions, async reset
// mid-instruction, then a random instruction stream against a behavioural model.
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  int path_q[$];

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  // {alu_control, src_a, src_b, pc_src, pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg}
  logic [14:0] ctrl_obs;
  assign ctrl_obs = {alu_control, alu_src_a, alu_src_b, pc_src, pc_en, iord,
                     ir_write, mem_write, reg_write, reg_dst, mem_to_reg};
  localparam logic [14:0] RESET_MASK = 15'h005C;

  mips_mc_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .iord        (iord),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequence of states an instruction walks through, starting at its fetch.
  task automatic make_path(input logic [5:0] op);
    path_q.delete();
    path_q.push_back(0);
    path_q.push_back(1);
    if (op == OP_LW)                 path_q = {path_q, 2, 3, 4};
    else if (op == OP_SW)            path_q = {path_q, 2, 5};
    else if (op == OP_RTYPE)         path_q = {path_q, 6, 7};
    else if (op == OP_BEQ)           path_q.push_back(8);
    else if (op == OP_BNE && BNE_EN) path_q.push_back(8);
    else if (op == OP_ADDI)          path_q = {path_q, 9, 10};
    else if (op == OP_J)             path_q.push_back(11);
  endtask

  function automatic logic [2:0] ref_funct(input logic [5:0] fn);
    if (fn == 6'b100010) return 3'b110;
    if (fn == 6'b100100) return 3'b000;
    if (fn == 6'b100101) return 3'b001;
    if (fn == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  function automatic logic [14:0] ref_ctrl(input int st, input logic [5:0] fn,
                                           input logic z, input logic is_bne);
    logic [2:0] f;
    logic a, pe, io, irw, mw, rw, rd, m2r;
    logic [1:0] b, ps;
    f = 3'b010; a = 0; b = 2'b00; ps = 2'b00;
    pe = 0; io = 0; irw = 0; mw = 0; rw = 0; rd = 0; m2r = 0;
    case (st)
      0:  begin b = 2'b01; irw = 1; pe = 1; end
      1:  b = 2'b11;
      2:  begin a = 1; b = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin a = 1; f = ref_funct(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin a = 1; f = 3'b110; ps = 2'b01; pe = is_bne ? ~z : z; end
      9:  begin a = 1; b = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {f, a, b, ps, pe, io, irw, mw, rw, rd, m2r};
  endfunction

  task automatic check_cycle(input int exp_st, input logic [5:0] fn, input logic is_bne);
    logic [14:0] exp_c;
    #1;
    exp_c = ref_ctrl(exp_st, fn, zero, is_bne);
    checks++;
    assert (state_o === exp_st[3:0]) else begin
      errors++;
      $error("FAIL state: got %0d expected %0d (opcode %b)", state_o, exp_st, opcode);
    end
    checks++;
    assert (ctrl_obs === exp_c) else begin
      errors++;
      $error("FAIL ctrl st%0d: got %h expected %h (opcode %b funct %b zero %b)",
             exp_st, ctrl_obs, exp_c, opcode, funct, zero);
    end
    @(negedge clk);
  endtask

  // zmode: 0/1 fixed zero flag, 2 random each cycle. max_steps truncates the walk.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int max_steps);
    logic is_bne;
    opcode = op;
    funct  = fn;
    is_bne = (op == OP_BNE) && BNE_EN;
    make_path(op);
    for (int i = 0; i < path_q.size() && i < max_steps; i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      check_cycle(path_q[i], fn, is_bne);
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    logic [5:0] ops[8];
    logic [5:0] fns[5];
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE, 6'b111111};
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

    reset_n = 1'b0;
    opcode  = OP_RTYPE;
    funct   = FN_ADD;
    zero    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    assert (state_o === 4'd0) else begin
      errors++; $error("FAIL reset_state: got %0d expected 0", state_o);
    end
    checks++;
    assert (ctrl_obs === (ref_ctrl(0, funct, zero, 1'b0) & ~RESET_MASK)) else begin
      errors++;
      $error("FAIL reset_ctrl: got %h expected %h", ctrl_obs,
             ref_ctrl(0, funct, zero, 1'b0) & ~RESET_MASK);
    end
    @(negedge clk);
    reset_n = 1'b1;

    run_instr(OP_LW,    $urandom_range(0, 63), 2, 99);
    run_instr(OP_RTYPE, FN_SLT, 2, 99);
    run_instr(OP_BEQ,   6'd0, 1, 99);
    run_instr(OP_BEQ,   6'd0, 0, 99);
    run_instr(OP_J,     6'd0, 2, 99);
    run_instr(6'b111111, FN_ADD, 2, 99);
    run_instr(OP_BNE,   6'd0, 0, 99);
    run_instr(OP_BNE,   6'd0, 1, 99);
    run_instr(OP_SW,    6'd0, 2, 99);
    run_instr(OP_ADDI,  6'd0, 2, 99);

    // Walk an R-type into RTYPEWB and pull reset there.
    run_instr(OP_RTYPE, FN_OR, 2, 3);
    #1;
    checks++;
    assert (reg_write === 1'b1 && state_o === 4'd7) else begin
      errors++; $error("FAIL pre_reset_wb: got rw=%b st=%0d expected rw=1 st=7", reg_write, state_o);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    assert (reg_write === 1'b0 && state_o === 4'd0) else begin
      errors++; $error("FAIL async_reset: got rw=%b st=%0d expected rw=0 st=0", reg_write, state_o);
    end
    checks++;
    assert (ctrl_obs === (ref_ctrl(0, funct, zero, 1'b0) & ~RESET_MASK)) else begin
      errors++;
      $error("FAIL async_reset_ctrl: got %h expected %h", ctrl_obs,
             ref_ctrl(0, funct, zero, 1'b0) & ~RESET_MASK);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_instr(OP_LW, FN_ADD, 2, 99);

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 6'b111111) op = 6'($urandom_range(48, 63));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, 2, 99);
    end

    #1;
    checks++;
    assert (state_o === 4'd0) else begin
      errors++; $error("FAIL final_state: got %0d expected 0", state_o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multi-cycle MIPS control unit: a Moore FSM plus an ALU-control decoder. It sits directly upstream of the 32-bit ALU. It drives the ALU's 3-bit function select, consumes the ALU's zero flag for branch resolution, and sequences every datapath enable (PC, IR, memory, register file) across the Fetch/Decode/Execute/Memory/Writeback cycles.

Parameters:
None. Opcode, funct and state encodings are fixed constants in the shared package.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] from the instruction register
funct  in  6  instr[5:0] from the instruction register
zero  in  1  ALU zero flag
alu_control  out  3  ALU F: 010 add, 110 sub, 000 and, 001 or, 111 slt
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
pc_en  out  1  PC load enable
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
ir_write  out  1  instruction register load
mem_write  out  1  data memory write
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = data register
state_o  out  4  current state encoding (debug)

Behaviour:
- Reset:
  - reset_n low asynchronously forces state to FETCH (0).
  - While reset_n is low, pc_en, ir_write, mem_write and reg_write are forced to 0. All other outputs show FETCH decode.
  - Deassertion mid-instruction is not special: the FSM always restarts at FETCH on the first clk edge after release.
- States (encoding in brackets); outputs are decoded from state only. Any output not listed for a state is 0.
  - FETCH[0]: iord=0, src_a=0, src_b=01, aluop=00, pc_src=00, ir_write=1, pcwrite=1. Next: DECODE.
  - DECODE[1]: src_a=0, src_b=11, aluop=00. Next depends on opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other opcode -> FETCH (executes as a NOP)
  - MEMADR[2]: src_a=1, src_b=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD[3]: iord=1. Next: MEMWB.
  - MEMWB[4]: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR[5]: iord=1, mem_write=1. Next: FETCH.
  - RTYPEEX[6]: src_a=1, src_b=00, aluop=10. Next: RTYPEWB.
  - RTYPEWB[7]: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BEQEX[8]: src_a=1, src_b=00, aluop=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEX[9]: src_a=1, src_b=10, aluop=00. Next: ADDIWB.
  - ADDIWB[10]: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
  - JEX[11]: pc_src=10, pcwrite=1. Next: FETCH.
  - Encodings 12-15 are unreachable; if entered, next state is FETCH and all enables are 0.
- pc_en = pcwrite | (branch & zero). This is combinational, so zero is used in the same BEQEX cycle.
- ALU decoder (combinational):
  - aluop 00 -> 010
  - aluop 01 -> 110
  - aluop 10 -> funct lookup: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010
  - aluop 11 -> 010
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.

Optional Feature:
MIPS_MC_BNE_EN.
- Defined: opcode 000101 (bne) goes DECODE -> BEQEX. An internal bne flag is latched in DECODE and cleared in FETCH. While it is set, pc_en = pcwrite | (branch & ~zero).
- Undefined: 000101 is treated as illegal (2-cycle NOP).

Decomposition:
- Package mips_mc_pkg:
  - state enum (4-bit, encodings above)
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE
  - funct constants
  - ALU-control constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - aluop constants
- One natural sub-module: mips_alu_decoder (aluop, funct -> alu_control).

Test Plan:
- Reset, then lw (opcode 100011): states 0,1,2,3,4,0. pc_en=1 only in cycle 0. iord=1 in state 3. reg_write=1 and mem_to_reg=1 in state 4.
- R-type with funct 101010: state 6 shows alu_control=111, src_a=1, src_b=00. State 7 shows reg_dst=1, reg_write=1.
- beq with zero=1 in BEQEX: pc_en=1, pc_src=01, alu_control=110. Repeat with zero=0: pc_en=0. Both return to FETCH.
- j: state 11 gives pc_en=1, pc_src=10. Opcode 111111 goes DECODE -> FETCH with no write enables asserted.
- Assert reset_n low asynchronously during RTYPEWB: reg_write drops immediately, state_o=0. After release, a full fetch occurs.
- MIPS_MC_BNE_EN defined: bne with zero=0 -> pc_en=1; with zero=1 -> pc_en=0. Macro undefined: bne -> 2-cycle NOP.
